// File: rtl/mel_filterbank.sv
// mel_filterbank: per-frame mel filterbank MAC engine over a stored power spectrum; define MEL_LOG2_EN for log2-compressed output
module mel_filterbank #(
   parameter int NUM_FILTERS  = 40,
   parameter int NFFT         = 512,
   parameter int INPUT_WIDTH  = 32,
   parameter int COEF_WIDTH   = 16,
   parameter int COEF_DEPTH   = 1024,
   parameter int ACC_WIDTH    = 48,
   parameter int OUTPUT_WIDTH = 16,
   localparam int NRFFT = NFFT / 2 + 1,
   localparam int SAW   = $clog2(NRFFT),
   localparam int FIW   = $clog2(NUM_FILTERS),
   localparam int CAW   = $clog2(COEF_DEPTH),
   localparam int DW    = 2 * SAW + CAW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    spec_we,
   input  logic [SAW-1:0]          spec_addr,
   input  logic [INPUT_WIDTH-1:0]  spec_data,
   input  logic                    desc_we,
   input  logic [FIW-1:0]          desc_addr,
   input  logic [DW-1:0]           desc_data,
   input  logic                    coef_we,
   input  logic [CAW-1:0]          coef_addr,
   input  logic [COEF_WIDTH-1:0]   coef_data,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    mel_valid_o,
   input  logic                    mel_ready_i,
   output logic [FIW-1:0]          mel_idx_o,
   output logic [OUTPUT_WIDTH-1:0] mel_value_o
);
   localparam int PW = INPUT_WIDTH + COEF_WIDTH;
   localparam int SW = (ACC_WIDTH > PW ? ACC_WIDTH : PW) + 1;
   localparam int EW = ACC_WIDTH - COEF_WIDTH;
   localparam logic [SW-1:0] AMAX = {{(SW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
   localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (COEF_WIDTH - 1);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ACC = 3'd2, DRAIN = 3'd3, OUT = 3'd4, DONE = 3'd5;
   logic [INPUT_WIDTH-1:0] spec_mem [NRFFT];
   logic [DW-1:0] desc_mem [NUM_FILTERS];
   logic [COEF_WIDTH-1:0] coef_mem [COEF_DEPTH];
   logic [2:0] state;
   logic [FIW-1:0] fidx;
   logic [SAW:0] k;
   logic [SAW-1:0] len, n;
   logic [CAW-1:0] ca;
   logic dr, v1, hit;
   logic [INPUT_WIDTH-1:0] s_q;
   logic [COEF_WIDTH-1:0] c_q;
   logic [ACC_WIDTH-1:0] acc, acc_nx;
   logic [PW-1:0] prod;
   logic [SW-1:0] sum;
   logic [ACC_WIDTH:0] rnd;
   logic [EW-1:0] energy;
   logic [OUTPUT_WIDTH-1:0] value;
   logic [DW-1:0] dsc;
   assign busy_o = state != IDLE;
   assign done_o = state == DONE;
   assign mel_valid_o = state == OUT;
   assign mel_idx_o = fidx;
   assign dsc = desc_mem[fidx];
   assign hit = state == ACC && n != len && k < (SAW+1)'(NRFFT);
   // host writes into the three RAMs, only while the engine is idle
   always_ff @(posedge clk) begin
      if (!busy_o) begin
         if (spec_we && {1'b0, spec_addr} < (SAW+1)'(NRFFT)) spec_mem[spec_addr] <= spec_data;
         if (desc_we && {1'b0, desc_addr} < (FIW+1)'(NUM_FILTERS)) desc_mem[desc_addr] <= desc_data;
         if (coef_we && {1'b0, coef_addr} < (CAW+1)'(COEF_DEPTH)) coef_mem[coef_addr] <= coef_data;
      end
   end
   // read stage: fetch spectrum bin and coefficient for in-range bins
   always_ff @(posedge clk) begin
      if (!rst_n) v1 <= 1'b0;
      else v1 <= hit;
      if (hit) begin
         s_q <= spec_mem[k[SAW-1:0]];
         c_q <= coef_mem[ca];
      end
   end
   // saturating multiply-accumulate and rounded, saturating energy
   always_comb begin
      prod = PW'(s_q) * PW'(c_q);
      sum = SW'(acc) + SW'(prod);
      acc_nx = sum > AMAX ? '1 : sum[ACC_WIDTH-1:0];
      rnd = {1'b0, acc} + HALF;
      energy = rnd[ACC_WIDTH] ? '1 : EW'(rnd >> COEF_WIDTH);
   end
`ifdef MEL_LOG2_EN
   logic [5:0] p;
   logic [EW-1:0] norm;
   // log2 compression: MSB position above the bits just below the MSB
   always_comb begin
      p = '0;
      for (int i = 0; i < EW; i++) if (energy[i]) p = 6'(i);
      norm = energy << (EW - 1 - int'(p));
      value = energy == '0 ? '0 : {p, norm[EW-2 -: OUTPUT_WIDTH-6]};
   end
`else
   // linear output clipped to the output range
   always_comb value = |(energy >> OUTPUT_WIDTH) ? '1 : energy[OUTPUT_WIDTH-1:0];
`endif
   // frame sequencer: load descriptor, accumulate bins, drain pipeline, hand off result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         fidx <= '0;
         acc <= '0;
         mel_value_o <= '0;
         k <= '0;
         len <= '0;
         n <= '0;
         ca <= '0;
         dr <= 1'b0;
      end else begin
         if (v1) acc <= acc_nx;
         case (state)
            IDLE: if (start_i) begin
               fidx <= '0;
               state <= LOAD;
            end
            LOAD: begin
               k <= {1'b0, dsc[DW-1 -: SAW]};
               len <= dsc[CAW +: SAW];
               ca <= dsc[CAW-1:0];
               n <= '0;
               dr <= 1'b0;
               acc <= '0;
               state <= dsc[CAW +: SAW] == '0 ? DRAIN : ACC;
            end
            ACC: if (n == len) state <= DRAIN;
            else begin
               n <= n + 1'b1;
               k <= k + 1'b1;
               ca <= ca == CAW'(COEF_DEPTH - 1) ? '0 : ca + 1'b1;
            end
            DRAIN: begin
               dr <= 1'b1;
               if (dr) begin
                  mel_value_o <= value;
                  state <= OUT;
               end
            end
            OUT: if (mel_ready_i) begin
               state <= fidx == FIW'(NUM_FILTERS - 1) ? DONE : LOAD;
               fidx <= fidx == FIW'(NUM_FILTERS - 1) ? fidx : fidx + 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mel_filterbank.sv
// tb_mel_filterbank: table-driven frame checks plus backpressure, abort and saturation sequences
module tb_mel_filterbank;
   logic clk = 1'b0, rst_n;
   logic spec_we, desc_we, coef_we, start_i, mel_ready_i;
   logic [8:0] spec_addr;
   logic [31:0] spec_data;
   logic [5:0] desc_addr;
   logic [27:0] desc_data;
   logic [9:0] coef_addr;
   logic [15:0] coef_data;
   logic busy_o, done_o, mel_valid_o;
   logic [5:0] mel_idx_o;
   logic [15:0] mel_value_o;
   int cyc = 0;
   int nvec = 0, nerr = 0;
   typedef struct {logic [8:0] ks; logic [8:0] kl; logic [9:0] cb; int energy; int lat;} vec_t;
   vec_t tbl [40];

   mel_filterbank #(.ACC_WIDTH(40)) dut (
      .clk(clk), .rst_n(rst_n),
      .spec_we(spec_we), .spec_addr(spec_addr), .spec_data(spec_data),
      .desc_we(desc_we), .desc_addr(desc_addr), .desc_data(desc_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .mel_valid_o(mel_valid_o), .mel_ready_i(mel_ready_i),
      .mel_idx_o(mel_idx_o), .mel_value_o(mel_value_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int expect_out(int e);
`ifdef MEL_LOG2_EN
      int p;
      logic [31:0] ev, m;
      if (e == 0) return 0;
      ev = e;
      p = 0;
      for (int i = 0; i < 32; i++) if (ev[i]) p = i;
      m = ev << (31 - p);
      return (p << 10) | int'(m[30:21]);
`else
      return e > 65535 ? 65535 : e;
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic spec_wr(input int a, input logic [31:0] d);
      spec_we = 1; spec_addr = 9'(a); spec_data = d;
      @(posedge clk); #1;
      spec_we = 0;
   endtask

   task automatic coef_wr(input int a, input logic [15:0] d);
      coef_we = 1; coef_addr = 10'(a); coef_data = d;
      @(posedge clk); #1;
      coef_we = 0;
   endtask

   task automatic load_desc();
      for (int i = 0; i < 40; i++) begin
         desc_we = 1; desc_addr = 6'(i); desc_data = {tbl[i].ks, tbl[i].kl, tbl[i].cb};
         @(posedge clk); #1;
      end
      desc_we = 0;
   endtask

   task automatic run_frame(input int stall, input int abort, input int inj);
      int rf, t;
      bit early;
      early = 0;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
      rf = cyc;
      check("busy_at_start", busy_o, 1);
      for (int i = 0; i < 40; i++) begin
         t = 0;
         while (!mel_valid_o && t < 600) begin
            if (done_o) early = 1;
            @(posedge clk); #1;
            t++;
         end
         check($sformatf("valid_seen[%0d]", i), mel_valid_o, 1);
         if (!mel_valid_o) return;
         check($sformatf("idx[%0d]", i), mel_idx_o, i);
         check($sformatf("value[%0d]", i), mel_value_o, expect_out(tbl[i].energy));
         check($sformatf("latency[%0d]", i), cyc - rf, tbl[i].lat);
         if (i == abort) begin
            rst_n = 0;
            @(posedge clk); #1;
            rst_n = 1;
            check("abort_busy", busy_o, 0);
            check("abort_done", done_o, 0);
            check("abort_valid", mel_valid_o, 0);
            check("abort_idx", mel_idx_o, 0);
            check("abort_value", mel_value_o, 0);
            early = 0;
            repeat (20) begin
               @(posedge clk); #1;
               if (done_o || busy_o) early = 1;
            end
            check("abort_quiet", early, 0);
            return;
         end
         if (i == inj) begin
            start_i = 1; spec_we = 1; spec_addr = 9'd2; spec_data = 32'd9999;
         end
         if (i == stall) begin
            mel_ready_i = 0;
            repeat (5) begin
               @(posedge clk); #1;
               check("hold_valid", mel_valid_o, 1);
               check("hold_idx", mel_idx_o, i);
               check("hold_value", mel_value_o, expect_out(tbl[i].energy));
            end
            mel_ready_i = 1;
         end
         @(posedge clk); #1;
         rf = cyc;
         start_i = 0;
         spec_we = 0;
      end
      check("done_pulse", done_o, 1);
      check("valid_after_last", mel_valid_o, 0);
      check("no_early_done", early, 0);
      @(posedge clk); #1;
      check("done_single", done_o, 0);
      check("idle_busy", busy_o, 0);
   endtask

   initial begin
      rst_n = 0; spec_we = 0; desc_we = 0; coef_we = 0; start_i = 0; mel_ready_i = 1;
      spec_addr = '0; spec_data = '0; desc_addr = '0; desc_data = '0; coef_addr = '0; coef_data = '0;
      for (int i = 0; i < 40; i++) tbl[i] = '{9'd0, 9'd0, 10'd0, 0, 3};
      tbl[0]  = '{9'd2,   9'd3, 10'd0,    300,    7};
      tbl[2]  = '{9'd255, 9'd4, 10'd3,    12725,  8};
      tbl[3]  = '{9'd10,  9'd2, 10'd1023, 613,    6};
      tbl[4]  = '{9'd100, 9'd2, 10'd7,    19900,  6};
      tbl[5]  = '{9'd300, 9'd3, 10'd0,    0,      7};
      tbl[6]  = '{9'd250, 9'd7, 10'd5,    176397, 11};
      tbl[39] = '{9'd20,  9'd1, 10'd2,    950,    5};
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_valid", mel_valid_o, 0);
      check("rst_idx", mel_idx_o, 0);
      check("rst_value", mel_value_o, 0);
      rst_n = 1;
      for (int c = 0; c < 1024; c++) coef_wr(c, 16'h0000);
      for (int c = 0; c < 3; c++) coef_wr(c, 16'h8000);
      coef_wr(3, 16'h4000);
      coef_wr(4, 16'h4000);
      for (int c = 5; c < 12; c++) coef_wr(c, 16'hFFFF);
      coef_wr(1023, 16'h2000);
      for (int k = 0; k < 257; k++) spec_wr(k, k == 0 ? 32'd7 : 32'(100 * (k - 1)));
      load_desc();
      run_frame(-1, -1, 3);
      run_frame(4, -1, -1);
      run_frame(-1, 17, -1);
      run_frame(-1, -1, -1);
      for (int k = 0; k < 257; k++) spec_wr(k, 32'hFFFF_FFFF);
      for (int c = 0; c < 256; c++) coef_wr(c, 16'hFFFF);
      for (int i = 0; i < 40; i++) tbl[i] = '{9'd0, 9'd0, 10'd0, 0, 3};
      tbl[0] = '{9'd0, 9'd256, 10'd0, 16777215, 260};
      tbl[1] = '{9'd0, 9'd1,   10'd0, 16777215, 5};
      load_desc();
      run_frame(-1, -1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mel_filterbank.md
MEL_FILTERBANK -- requirements
Module: mel_filterbank

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 40: number of mel filters per frame.
REQ-002 SHALL have parameter NFFT, default 512; NRFFT = NFFT/2+1 spectrum bins.
REQ-003 SHALL have parameter INPUT_WIDTH, default 32: unsigned power-spectrum sample width.
REQ-004 SHALL have parameter COEF_WIDTH, default 16: unsigned coefficient, Q0.COEF_WIDTH.
REQ-005 SHALL have parameter COEF_DEPTH, default 1024: coefficient RAM entries.
REQ-006 SHALL have parameter ACC_WIDTH, default 48: accumulator width.
REQ-007 SHALL have parameter OUTPUT_WIDTH, default 16: result width.
REQ-008 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset, synchronous, active-low).
REQ-009 SHALL have ports spec_we (in, 1), spec_addr (in, clog2(NRFFT)) and spec_data (in, INPUT_WIDTH): spectrum write.
REQ-010 SHALL have ports desc_we (in, 1), desc_addr (in, clog2(NUM_FILTERS)) and desc_data (in, 2*clog2(NRFFT)+clog2(COEF_DEPTH)): descriptor {k_start, k_len, coef_base}, MSB first.
REQ-011 SHALL have ports coef_we (in, 1), coef_addr (in, clog2(COEF_DEPTH)) and coef_data (in, COEF_WIDTH): coefficient write.
REQ-012 SHALL have ports start_i (in, 1) to start a frame, busy_o (out, 1) and done_o (out, 1, one-cycle pulse).
REQ-013 SHALL have ports mel_valid_o (out, 1), mel_ready_i (in, 1), mel_idx_o (out, clog2(NUM_FILTERS)) and mel_value_o (out, OUTPUT_WIDTH).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, ACC, DRAIN, OUT and DONE.
REQ-015 IDLE->LOAD SHALL occur on start_i=1 with filter index 0; start_i in any other state SHALL be ignored.
REQ-016 LOAD SHALL take 1 cycle: read descriptor, clear accumulator, go to ACC, or go to DRAIN if k_len=0.
REQ-017 ACC SHALL issue one bin per cycle for k_start..k_start+k_len-1; bins >= NRFFT SHALL be skipped, contributing 0.
REQ-018 Each issued bin SHALL read spec[k] and coef[coef_base+n], n = 0..k_len-1, with coefficient address wrapping modulo COEF_DEPTH.
REQ-019 Products SHALL be accumulated exactly as INPUT_WIDTH+COEF_WIDTH bit products, 2-stage read/MAC pipeline.
REQ-020 The accumulator SHALL saturate at 2^ACC_WIDTH-1 and never wrap.
REQ-021 DRAIN SHALL last 2 cycles; energy SHALL then equal (acc + 2^(COEF_WIDTH-1)) >> COEF_WIDTH, with the add saturating.
REQ-022 OUT SHALL assert mel_valid_o with mel_idx_o = filter index; value and index SHALL be held stable until mel_valid_o & mel_ready_i.
REQ-023 After the handshake, the FSM SHALL go to LOAD with the next index, or to DONE after index NUM_FILTERS-1.
REQ-024 DONE SHALL pulse done_o for 1 cycle, then return to IDLE.
REQ-025 With mel_ready_i held high, mel_valid_o for a filter of length L SHALL rise exactly L+4 cycles after LOAD entry (k_len=0: 3 cycles).
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 spec_we, desc_we and coef_we SHALL be ignored while busy_o=1; spec_addr >= NRFFT SHALL be ignored in IDLE.
REQ-028 Each output SHALL be emitted exactly once per filter, in ascending index order.

Reset
REQ-029 On rst_n=0 at a clock edge, the FSM SHALL enter IDLE and clear busy_o, done_o, mel_valid_o, mel_idx_o, mel_value_o and the accumulator.
REQ-030 Reset mid-frame SHALL abort the frame without done_o; RAM contents SHALL be retained.

Configuration
REQ-031 With macro MEL_LOG2_EN defined, mel_value_o SHALL be log2 compressed: 0 if energy=0, else the upper 6 bits hold the MSB position and the low OUTPUT_WIDTH-6 bits hold the bits below the MSB, truncated or zero-padded.
REQ-032 Without MEL_LOG2_EN, mel_value_o SHALL be energy saturated to 2^OUTPUT_WIDTH-1.

Verification
REQ-033 Filter 0 {k_start=2, k_len=3, base=0}, coefs 0x8000 x3, spec[2..4]=100,200,300, ready=1 -> energy 300, mel_valid_o rises 7 cycles after LOAD, mel_idx_o=0.
REQ-034 Filter with k_len=0 -> mel_value_o=0 and mel_valid_o 3 cycles after LOAD; with MEL_LOG2_EN also 0.
REQ-035 Bins 0xFFFFFFFF and coefs 0xFFFF over 256 bins with ACC_WIDTH=40 -> accumulator saturates; value = 2^OUTPUT_WIDTH-1 without MEL_LOG2_EN.
REQ-036 mel_ready_i low for 5 cycles during OUT -> mel_valid_o, mel_idx_o and mel_value_o held stable; no filter skipped; 40 outputs then a single done_o pulse.
REQ-037 rst_n low at filter 17 -> IDLE next cycle with all outputs 0 and no done_o; a new start_i reproduces identical results from index 0.
REQ-038 start_i and spec_we pulsed mid-frame -> both ignored, spectrum unchanged, frame results unaffected.
